// File: rtl/pio_irq_service.sv
// pio_irq_service: programs a PIO interrupt mask and services PIO edge
// interrupts. Each serviced interrupt reads the edge-capture and data
// registers, clears the captured edges, and queues a {capture, level} event
// in a first-word fall-through FIFO with a sticky overflow flag.
module pio_irq_service #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIDTH      = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_load,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  input  logic             irq_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_capture,
  output logic [WIDTH-1:0] evt_level,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CFG_WR, RD_CAP, CAP_WAIT, RD_DAT, DAT_WAIT, CLR_WR, PUSH
  } state_t;

  state_t             state;
  logic               cfg_pending;
  logic [WIDTH-1:0]   mask_q;
  logic [WIDTH-1:0]   cap_reg;
  logic [WIDTH-1:0]   lvl_reg;

  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_req;
  logic               push_ok;

  // Upper readdata bits beyond WIDTH carry nothing for this PIO.
  logic               unused_rdata;
  assign unused_rdata = ^m_readdata;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign evt_valid   = !fifo_empty;
  assign pop         = evt_valid && evt_ready;
  assign push_req    = (state == PUSH);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok     = push_req && (!fifo_full || pop);
  assign evt_capture = mem[rd_ptr[AW-1:0]][2*WIDTH-1:WIDTH];
  assign evt_level   = mem[rd_ptr[AW-1:0]][WIDTH-1:0];

  // Latch the most recent requested mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (cfg_load) begin
      mask_q <= cfg_mask;
    end
  end

  // Service FSM; bus outputs are registered alongside the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cfg_pending  <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= 2'd0;
      m_writedata  <= '0;
      cap_reg      <= '0;
      lvl_reg      <= '0;
    end else begin
      if (cfg_load) begin
        cfg_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          // A load arriving in this very cycle counts as pending and its
          // mask is taken straight from the input, so config beats irq.
          if (cfg_pending || cfg_load) begin
            state        <= CFG_WR;
            cfg_pending  <= 1'b0;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b0;
            m_address    <= 2'd2;
            m_writedata  <= 32'(cfg_load ? cfg_mask : mask_q);
          end else if (irq_in) begin
            state        <= RD_CAP;
            m_chipselect <= 1'b1;
            m_write_n    <= 1'b1;
            m_address    <= 2'd3;
          end
        end
        CFG_WR: begin
          state        <= IDLE;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          m_address    <= 2'd0;
          m_writedata  <= '0;
        end
        RD_CAP: begin
          state        <= CAP_WAIT;
          m_chipselect <= 1'b0;
          m_address    <= 2'd3;
        end
        CAP_WAIT: begin
          cap_reg      <= m_readdata[WIDTH-1:0];
          state        <= RD_DAT;
          m_chipselect <= 1'b1;
          m_address    <= 2'd0;
        end
        RD_DAT: begin
          state        <= DAT_WAIT;
          m_chipselect <= 1'b0;
          m_address    <= 2'd0;
        end
        DAT_WAIT: begin
          lvl_reg      <= m_readdata[WIDTH-1:0];
          state        <= CLR_WR;
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= 2'd3;
          m_writedata  <= 32'(cap_reg);
        end
        CLR_WR: begin
          state        <= PUSH;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          m_address    <= 2'd0;
          m_writedata  <= '0;
        end
        PUSH: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          m_chipselect <= 1'b0;
          m_write_n    <= 1'b1;
          m_address    <= 2'd0;
          m_writedata  <= '0;
        end
      endcase
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {cap_reg, lvl_reg};
    end
  end

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pio_irq_service.sv
// Testbench for pio_irq_service with a small behavioural PIO slave
// (falling-edge capture, mask register, registered readdata).
module tb_pio_irq_service;

  localparam int unsigned WIDTH      = 18;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [WIDTH-1:0] ALL1  = '1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pio_rst_n;
  logic [WIDTH-1:0] cfg_mask;
  logic             cfg_load;
  logic [1:0]       m_address;
  logic             m_chipselect;
  logic             m_write_n;
  logic [31:0]      m_writedata;
  logic [31:0]      m_readdata;
  logic             irq_in;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_capture;
  logic [WIDTH-1:0] evt_level;
  logic             overflow;
  logic             overflow_clr;

  always #5 clk = ~clk;

  pio_irq_service #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_mask(cfg_mask), .cfg_load(cfg_load),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq_in(irq_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_capture(evt_capture),
    .evt_level(evt_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  // Behavioural PIO slave
  logic [WIDTH-1:0] in_port, in_q, irq_mask, edge_cap;
  logic [31:0]      last_clr_wdata;
  int unsigned      wr_count;

  always @(posedge clk or negedge pio_rst_n) begin
    if (!pio_rst_n) begin
      in_q           <= '0;
      irq_mask       <= '0;
      edge_cap       <= '0;
      m_readdata     <= '0;
      last_clr_wdata <= '0;
      wr_count       <= 0;
    end else begin
      in_q <= in_port;
      case (m_address)
        2'd0:    m_readdata <= 32'(in_port);
        2'd2:    m_readdata <= 32'(irq_mask);
        2'd3:    m_readdata <= 32'(edge_cap);
        default: m_readdata <= '0;
      endcase
      if (m_chipselect && !m_write_n) begin
        wr_count <= wr_count + 1;
        if (m_address == 2'd2) irq_mask <= m_writedata[WIDTH-1:0];
      end
      if (m_chipselect && !m_write_n && m_address == 2'd3) begin
        edge_cap       <= (edge_cap & ~m_writedata[WIDTH-1:0]) | (in_q & ~in_port);
        last_clr_wdata <= m_writedata;
      end else begin
        edge_cap <= edge_cap | (in_q & ~in_port);
      end
    end
  end
  assign irq_in = |(edge_cap & irq_mask);

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic checkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nclk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Return to all-ones (rising only), then drop to v to create falling edges.
  task automatic fall_to(input logic [WIDTH-1:0] v);
    in_port = ALL1;
    nclk(3);
    in_port = v;
  endtask

  task automatic wait_irq(input string name);
    int unsigned t = 0;
    while (irq_in !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkb({name, "_irq"}, irq_in, 1'b1);
  endtask

  task automatic wait_valid(input string name, output int unsigned lat);
    lat = 0;
    while (evt_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkb({name, "_valid"}, evt_valid, 1'b1);
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] bitv(input int unsigned k);
    logic [WIDTH-1:0] b;
    b    = '0;
    b[k] = 1'b1;
    return b;
  endfunction

  typedef struct {
    logic [WIDTH-1:0] next;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] lvl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned t;
    int unsigned wc;

    vecs[0] = '{next: 18'h3FFDF, cap: 18'h00020, lvl: 18'h3FFDF};
    vecs[1] = '{next: 18'h3FFFE, cap: 18'h00001, lvl: 18'h3FFFE};
    vecs[2] = '{next: 18'h1FFFF, cap: 18'h20000, lvl: 18'h1FFFF};
    vecs[3] = '{next: 18'h3F0FF, cap: 18'h00F00, lvl: 18'h3F0FF};
    vecs[4] = '{next: 18'h00000, cap: 18'h3FFFF, lvl: 18'h00000};
    vecs[5] = '{next: 18'h2AAAA, cap: 18'h15555, lvl: 18'h2AAAA};

    reset_n      = 1'b0;
    pio_rst_n    = 1'b0;
    cfg_mask     = '0;
    cfg_load     = 1'b0;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    in_port      = ALL1;

    // Reset state
    nclk(2);
    checkb("rst_valid", evt_valid, 1'b0);
    checkb("rst_overflow", overflow, 1'b0);
    checkb("rst_cs", m_chipselect, 1'b0);
    checkb("rst_wr_n", m_write_n, 1'b1);
    checkn("rst_addr", 32'(m_address), 32'd0);
    checkn("rst_wdata", m_writedata, 32'd0);
    reset_n   = 1'b1;
    pio_rst_n = 1'b1;
    nclk(2);

    // Configuration write
    cfg_mask = ALL1;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    checkb("cfg_cs", m_chipselect, 1'b1);
    checkb("cfg_wr_n", m_write_n, 1'b0);
    checkn("cfg_addr", 32'(m_address), 32'd2);
    checkn("cfg_wdata", m_writedata, 32'h0003FFFF);
    @(negedge clk);
    checkb("cfg_cs_end", m_chipselect, 1'b0);
    checkb("cfg_wr_n_end", m_write_n, 1'b1);
    checkv("cfg_pio_mask", irq_mask, ALL1);

    // Single-edge events from the table, FIFO empty each time
    for (int unsigned i = 0; i < 6; i++) begin
      fall_to(vecs[i].next);
      wait_irq($sformatf("vec%0d", i));
      wait_valid($sformatf("vec%0d", i), lat);
      checkn($sformatf("vec%0d_latency", i), lat, 32'd7);
      checkv($sformatf("vec%0d_capture", i), evt_capture, vecs[i].cap);
      checkv($sformatf("vec%0d_level", i), evt_level, vecs[i].lvl);
      checkb($sformatf("vec%0d_irq_cleared", i), irq_in, 1'b0);
      checkn($sformatf("vec%0d_clr_wdata", i), last_clr_wdata, 32'(vecs[i].cap));
      pop_one();
      checkb($sformatf("vec%0d_empty", i), evt_valid, 1'b0);
    end

    // Overflow: five events, no consumer
    for (int unsigned k = 0; k < 5; k++) begin
      fall_to(ALL1 & ~bitv(k));
      nclk(12);
      if (k == 3) checkb("ovf_before_drop", overflow, 1'b0);
    end
    checkb("ovf_set", overflow, 1'b1);
    checkb("ovf_valid", evt_valid, 1'b1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    checkb("ovf_cleared", overflow, 1'b0);
    for (int unsigned k = 0; k < 4; k++) begin
      checkb($sformatf("ovf_q%0d_valid", k), evt_valid, 1'b1);
      checkv($sformatf("ovf_q%0d_capture", k), evt_capture, bitv(k));
      checkv($sformatf("ovf_q%0d_level", k), evt_level, ALL1 & ~bitv(k));
      pop_one();
    end
    checkb("ovf_dropped", evt_valid, 1'b0);

    // Full FIFO with a pop in the PUSH cycle
    for (int unsigned k = 6; k < 10; k++) begin
      fall_to(ALL1 & ~bitv(k));
      nclk(12);
    end
    fall_to(ALL1 & ~bitv(10));
    t = 0;
    while (!(m_chipselect && !m_write_n && m_address == 2'd3) && t < 30) begin
      @(negedge clk);
      t++;
    end
    checkb("full_clr_wr_seen", m_chipselect && !m_write_n && m_address == 2'd3, 1'b1);
    @(negedge clk);
    checkv("full_head", evt_capture, bitv(6));
    pop_one();
    checkb("full_no_overflow", overflow, 1'b0);
    for (int unsigned k = 7; k < 11; k++) begin
      checkb($sformatf("full_q%0d_valid", k), evt_valid, 1'b1);
      checkv($sformatf("full_q%0d_capture", k), evt_capture, bitv(k));
      pop_one();
    end
    checkb("full_empty", evt_valid, 1'b0);

    // Priority: cfg_load and irq_in in the same IDLE cycle
    fall_to(ALL1 & ~bitv(11));
    @(negedge clk);
    checkb("prio_irq", irq_in, 1'b1);
    cfg_mask = ALL1;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    checkb("prio_cfg_cs", m_chipselect, 1'b1);
    checkb("prio_cfg_wr_n", m_write_n, 1'b0);
    checkn("prio_cfg_addr", 32'(m_address), 32'd2);
    @(negedge clk);
    checkb("prio_idle_cs", m_chipselect, 1'b0);
    @(negedge clk);
    checkb("prio_rdcap_cs", m_chipselect, 1'b1);
    checkb("prio_rdcap_wr_n", m_write_n, 1'b1);
    checkn("prio_rdcap_addr", 32'(m_address), 32'd3);
    wait_valid("prio", lat);
    checkv("prio_capture", evt_capture, bitv(11));
    pop_one();

    // cfg_load during service is applied after PUSH with the latched mask
    fall_to(ALL1 & ~bitv(12));
    wait_irq("pend");
    nclk(2);
    cfg_mask = ALL1;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    cfg_mask = 18'h12345;
    wait_valid("pend", lat);
    checkb("pend_idle_cs", m_chipselect, 1'b0);
    checkb("pend_idle_wr_n", m_write_n, 1'b1);
    @(negedge clk);
    checkb("pend_cfg_cs", m_chipselect, 1'b1);
    checkb("pend_cfg_wr_n", m_write_n, 1'b0);
    checkn("pend_cfg_addr", 32'(m_address), 32'd2);
    checkn("pend_cfg_wdata", m_writedata, 32'h0003FFFF);
    checkv("pend_capture", evt_capture, bitv(12));
    pop_one();
    nclk(2);

    // Reset asserted in DAT_WAIT
    fall_to(ALL1 & ~bitv(13));
    wait_irq("rstmid");
    nclk(4);
    wc = wr_count;
    reset_n = 1'b0;
    #1;
    checkb("rstmid_valid", evt_valid, 1'b0);
    checkb("rstmid_cs", m_chipselect, 1'b0);
    checkb("rstmid_wr_n", m_write_n, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    checkb("rstmid_after_valid", evt_valid, 1'b0);
    checkb("rstmid_after_wr_n", m_write_n, 1'b1);
    checkn("rstmid_no_write", wr_count, wc);
    wait_valid("rstmid_reservice", lat);
    checkv("rstmid_capture", evt_capture, bitv(13));
    pop_one();
    checkb("rstmid_single_event", evt_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
